frame_scan_ctrl: RTL and testbench

- Sequences one full-frame pass from the capture buffer to the VGA frame buffer in the clk25 domain.
- Issues read addresses to the capture BRAM and tags each read with x/y through a latency-matched pipeline.
- Presents each returned pixel to the processing datapath and issues the matching write address and write enable to the VGA buffer.
- Supports start/done handshake, pause (freeze-frame), and a 2:1 decimated scan mode for the low-resolution/inference path.

---
 rtl/frame_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_frame_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl
// Walks the capture buffer once per accepted frame_start. It issues read
// addresses to the capture BRAM and carries each read's x/y/write-address
// tag down a shift register matched to the BRAM read latency. Each returned
// pixel is presented to the processing datapath, and the result is written
// to the VGA frame buffer in the same cycle.
//
// Ports:
//   clk25, rst_n         clock, asynchronous active-low reset
//   frame_start          single-cycle request to scan one frame
//   pause                level, freezes address issue while high
//   decim                level, sampled at an accepted frame_start
//                        (1 = every 2nd pixel of every 2nd line)
//   din                  capture BRAM read data
//   addr_mem0            capture BRAM read address
//   pix_valid/x/y/data   tagged pixel presented to the processing datapath
//   proc_in              combinational processing result for that pixel
//   addr_mem1, we, dout  VGA buffer write port
//   busy                 scan in progress, including pipeline drain
//   done                 one-cycle pulse after the last write of a frame
//   frame_cnt            completed frames, wraps 255->0
module frame_scan_ctrl #(
    parameter int width  = 640,
    parameter int height = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pause,
    input  logic              decim,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] addr_mem0,
    output logic              pix_valid,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic [7:0]        pix_data,
    input  logic [3:0]        proc_in,
    output logic [ADDR_W-1:0] addr_mem1,
    output logic              we,
    output logic [3:0]        dout,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [9:0]        X_LAST0    = 10'(width - 1);
    localparam logic [9:0]        X_LAST1    = 10'(width - 2);
    localparam logic [8:0]        Y_LAST0    = 9'(height - 1);
    localparam logic [8:0]        Y_LAST1    = 9'(height - 2);
    // Jump from (width-2, y) to (0, y+2) in decimated mode.
    localparam logic [ADDR_W-1:0] LINE_SKIP  = ADDR_W'(width + 2);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

    state_t            state, state_next;
    logic              mode_r;
    logic [9:0]        x_r;
    logic [8:0]        y_r;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        drain_cnt;

    logic              accept, issue, drain_done, line_end, frame_last;
    logic [9:0]        x_step;
    logic [8:0]        y_step;
    logic [ADDR_W-1:0] rd_step;

    // Tag pipeline; stage RD_LAT-1 lines up with din.
    logic              pipe_v [RD_LAT];
    logic [9:0]        pipe_x [RD_LAT];
    logic [8:0]        pipe_y [RD_LAT];
    logic [ADDR_W-1:0] pipe_a [RD_LAT];

    assign x_step  = mode_r ? 10'd2 : 10'd1;
    assign y_step  = mode_r ? 9'd2 : 9'd1;
    assign rd_step = (mode_r && line_end) ? LINE_SKIP :
                     (mode_r ? ADDR_W'(2) : ADDR_W'(1));

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // frame_start is refused during the done cycle as well, even though the
    // FSM is already back in IDLE there.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        drain_done = 1'b0;
        line_end   = mode_r ? (x_r == X_LAST1) : (x_r == X_LAST0);
        frame_last = line_end && (mode_r ? (y_r == Y_LAST1) : (y_r == Y_LAST0));
        case (state)
            IDLE: begin
                if (frame_start && !done) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!pause) begin
                    issue = 1'b1;
                    if (frame_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The write address counts issued pixels, which is the read address in
    // full mode and the packed decimated address in 2:1 mode. Scan counters
    // stop on the last pixel so addr_mem0 holds it afterwards. Tag fields
    // only move with valid entries, so addr_mem1 holds while we is low.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
                pipe_a[i] <= '0;
            end
        end else begin
            done <= drain_done;
            if (drain_done) frame_cnt <= frame_cnt + 8'd1;

            if (accept)          busy <= 1'b1;
            else if (drain_done) busy <= 1'b0;

            if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
            else                drain_cnt <= '0;

            if (accept) begin
                mode_r  <= decim;
                x_r     <= '0;
                y_r     <= '0;
                rd_addr <= '0;
                wr_addr <= '0;
            end else if (issue && !frame_last) begin
                rd_addr <= rd_addr + rd_step;
                wr_addr <= wr_addr + ADDR_W'(1);
                if (line_end) begin
                    x_r <= '0;
                    y_r <= y_r + y_step;
                end else begin
                    x_r <= x_r + x_step;
                end
            end

            pipe_v[0] <= issue;
            if (issue) begin
                pipe_x[0] <= x_r;
                pipe_y[0] <= y_r;
                pipe_a[0] <= wr_addr;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_x[i] <= pipe_x[i-1];
                    pipe_y[i] <= pipe_y[i-1];
                    pipe_a[i] <= pipe_a[i-1];
                end
            end
        end
    end

    assign addr_mem0 = rd_addr;
    assign pix_valid = pipe_v[RD_LAT-1];
    assign pix_x     = pipe_x[RD_LAT-1];
    assign pix_y     = pipe_y[RD_LAT-1];
    assign pix_data  = din;
    assign addr_mem1 = pipe_a[RD_LAT-1];
    assign we        = pipe_v[RD_LAT-1];
    assign dout      = proc_in;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb_frame_scan_ctrl
// Three copies of frame_scan_ctrl (8x4 frame; read latency 2, 1 and 4)
// share pause/decim/reset. Each copy has its own frame_start and its own
// BRAM model that returns address[7:0] after the instance's latency.
// Expected writes are queued per frame. A monitor walks the queue
// independently for each copy.
module tb_frame_scan_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int LAT2 = 4;

    typedef struct {
        logic [18:0] addr;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [7:0]  data;
    } exp_t;

    logic        clk25;
    logic        rst_n;
    logic        pause;
    logic        decim;
    logic        fs     [3];
    logic        we_a   [3];
    logic        pv_a   [3];
    logic [18:0] a1_a   [3];
    logic [9:0]  px_a   [3];
    logic [8:0]  py_a   [3];
    logic [7:0]  pd_a   [3];
    logic [3:0]  dout_a [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic [7:0]  fc_a   [3];

    int          lat [3] = '{LAT0, LAT1, LAT2};
    int          ptr [3];
    exp_t        exp_q[$];
    logic [7:0]  exp_fc;
    int          tests;
    int          fails;

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2);
        logic [18:0] addr0;
        logic [7:0]  din_m;
        logic [3:0]  proc;
        logic [18:0] dl [4];

        always @(posedge clk25) begin
            dl[0] <= addr0;
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
        end
        assign din_m = dl[LAT-1][7:0];
        assign proc  = pd_a[g][3:0] ^ pd_a[g][7:4];

        frame_scan_ctrl #(.width(W), .height(H), .ADDR_W(19), .RD_LAT(LAT)) u_dut (
            .clk25       (clk25),
            .rst_n       (rst_n),
            .frame_start (fs[g]),
            .pause       (pause),
            .decim       (decim),
            .din         (din_m),
            .addr_mem0   (addr0),
            .pix_valid   (pv_a[g]),
            .pix_x       (px_a[g]),
            .pix_y       (py_a[g]),
            .pix_data    (pd_a[g]),
            .proc_in     (proc),
            .addr_mem1   (a1_a[g]),
            .we          (we_a[g]),
            .dout        (dout_a[g]),
            .busy        (busy_a[g]),
            .done        (done_a[g]),
            .frame_cnt   (fc_a[g])
        );
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write is compared against the next queued pixel.
    // While reset is low, pending expectations of the abandoned frame are skipped.
    always @(negedge clk25) begin
        if (!rst_n) begin
            for (int g = 0; g < 3; g++) ptr[g] = exp_q.size();
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (we_a[g]) begin
                    if (ptr[g] >= exp_q.size()) begin
                        checkOutput($sformatf("unexpected write dut%0d", g),
                                    64'(a1_a[g]), 64'h7ffff);
                    end else begin
                        checkOutput($sformatf("write %0d dut%0d {v,addr,x,y,data,dout}", ptr[g], g),
                                    64'({pv_a[g], a1_a[g], px_a[g], py_a[g], pd_a[g], dout_a[g]}),
                                    64'({1'b1, exp_q[ptr[g]].addr, exp_q[ptr[g]].x, exp_q[ptr[g]].y,
                                         exp_q[ptr[g]].data,
                                         exp_q[ptr[g]].data[3:0] ^ exp_q[ptr[g]].data[7:4]}));
                    end
                    ptr[g]++;
                end
            end
        end
    end

    task automatic pushFrame(input bit mode);
        exp_t e;
        int   st;
        st = mode ? 2 : 1;
        for (int y = 0; y < H; y += st) begin
            for (int x = 0; x < W; x += st) begin
                e.addr = mode ? 19'((y / 2) * (W / 2) + x / 2) : 19'(y * W + x);
                e.x    = 10'(x);
                e.y    = 9'(y);
                e.data = 8'(y * W + x);
                exp_q.push_back(e);
            end
        end
    endtask

    // One frame on all three copies. The pause window is given in cycles
    // after frame_start; delay is how many issue cycles it actually costs.
    task automatic applyStimulus(input bit mode, input int p_from, input int p_to,
                                 input int delay, input bit retrig);
        int npix;
        int first_we [3];
        int done_at  [3];
        int done_n   [3];
        int kmax;
        npix = mode ? 8 : 32;
        kmax = 1 + npix + delay + LAT2 + 2;
        for (int g = 0; g < 3; g++) begin
            first_we[g] = -1;
            done_at[g]  = -1;
            done_n[g]   = 0;
        end
        pushFrame(mode);
        @(posedge clk25); #1;
        decim = mode;
        pause = (p_from <= 0 && p_to > 0);
        for (int g = 0; g < 3; g++) fs[g] = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) begin
                @(posedge clk25); #1;
                decim = ~mode;
                pause = (k >= p_from && k < p_to);
                for (int g = 0; g < 3; g++)
                    fs[g] = retrig && (k == 10 || k == 1 + npix + delay + lat[g]);
            end
            @(negedge clk25);
            for (int g = 0; g < 3; g++) begin
                if (we_a[g] && first_we[g] < 0) first_we[g] = k;
                if (done_a[g]) begin
                    done_n[g]++;
                    done_at[g] = k;
                end
            end
        end
        pause  = 1'b0;
        decim  = 1'b0;
        for (int g = 0; g < 3; g++) fs[g] = 1'b0;
        exp_fc = exp_fc + 8'd1;
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("first we cycle dut%0d", g), 64'(first_we[g]), 64'(1 + lat[g]));
            checkOutput($sformatf("done cycle dut%0d", g), 64'(done_at[g]),
                        64'(1 + npix + delay + lat[g]));
            checkOutput($sformatf("done pulses dut%0d", g), 64'(done_n[g]), 64'd1);
            checkOutput($sformatf("idle after frame dut%0d", g), 64'(busy_a[g]), 64'd0);
            checkOutput($sformatf("writes seen dut%0d", g), 64'(ptr[g]), 64'(exp_q.size()));
            checkOutput($sformatf("frame_cnt dut%0d", g), 64'(fc_a[g]), 64'(exp_fc));
        end
    endtask

    // Drops reset while pixel 20 is on the read address, mid-frame.
    task automatic applyResetMidFrame();
        pushFrame(1'b0);
        @(posedge clk25); #1;
        for (int g = 0; g < 3; g++) fs[g] = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk25); #1;
            for (int g = 0; g < 3; g++) fs[g] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++)
            checkOutput($sformatf("async reset {we,busy} dut%0d", g),
                        64'({we_a[g], busy_a[g]}), 64'd0);
        repeat (3) @(posedge clk25);
        #1 rst_n = 1'b1;
        exp_fc = 8'd0;
        repeat (6) @(negedge clk25);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("post-reset quiet {busy,fc} dut%0d", g),
                        64'({busy_a[g], fc_a[g]}), 64'd0);
            checkOutput($sformatf("post-reset writes dut%0d", g), 64'(ptr[g]), 64'(exp_q.size()));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        exp_fc = 8'd0;
        rst_n  = 1'b0;
        pause  = 1'b0;
        decim  = 1'b0;
        for (int g = 0; g < 3; g++) fs[g] = 1'b0;
        repeat (3) @(posedge clk25);
        #1 rst_n = 1'b1;
        @(negedge clk25);
        for (int g = 0; g < 3; g++)
            checkOutput($sformatf("reset state dut%0d", g),
                        64'({we_a[g], busy_a[g], done_a[g], fc_a[g], a1_a[g], px_a[g], py_a[g]}),
                        64'd0);

        applyStimulus(1'b0, -1, -1, 0, 1'b0);  // full scan
        applyStimulus(1'b1, 0, 1, 0, 1'b0);    // decimated, pause only in IDLE
        applyStimulus(1'b0, 11, 16, 5, 1'b0);  // pause from issued pixel 10 for 5 cycles
        applyStimulus(1'b0, 33, 38, 0, 1'b0);  // pause during drain
        applyStimulus(1'b0, -1, -1, 0, 1'b1);  // frame_start while busy and in done cycle
        applyResetMidFrame();
        applyStimulus(1'b0, -1, -1, 0, 1'b0);  // restart after reset
        for (int f = 0; f < 255; f++) applyStimulus(1'b1, -1, -1, 0, 1'b0);
        for (int g = 0; g < 3; g++)
            checkOutput($sformatf("frame_cnt wrap dut%0d", g), 64'(fc_a[g]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
